// File: rtl/keeper_round_ctrl_if.sv
// Video timing + colour bundle passed along the VGA renderer chain.
// Modport "in" is the upstream side of a stage, "out" the downstream side.
interface vga_if;
   logic [10:0] vcount;
   logic        vsync;
   logic        vblnk;
   logic [10:0] hcount;
   logic        hsync;
   logic        hblnk;
   logic [11:0] rgb;

   modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
   modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/keeper_round_ctrl.sv
// Goalkeeper-mode round controller: best-of-NUM_ROUNDS session, target overlay and UART frames.
// Optional macro KEEPER_BLINK_EN makes the countdown target blink with half-period BLINK_TICKS.
module keeper_round_ctrl #(
   parameter int         ENGAGE_TICKS    = 65_019_506,
   parameter int         COUNTDOWN_TICKS = 65_019_506,
   parameter int         RESULT_TICKS    = 13_003_901,
   parameter int         TARGET_SIZE     = 100,
   parameter int         NUM_ROUNDS      = 5,
   parameter int         BLINK_TICKS     = 8_127_438,
   parameter logic [1:0] GS_KEEPER       = 2'd2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] xpos,
   input  logic [11:0] ypos,
   input  logic [1:0]  game_state,
   input  logic [9:0]  shot_xpos,
   input  logic [9:0]  shot_ypos,
   vga_if.in           in,
   vga_if.out          out,
   output logic        is_scored,
   output logic        round_done,
   output logic [3:0]  goals,
   output logic        end_gk,
   output logic [7:0]  data_to_transmit
);

   localparam int T_A   = (ENGAGE_TICKS > COUNTDOWN_TICKS) ? ENGAGE_TICKS : COUNTDOWN_TICKS;
   localparam int T_B   = (T_A > RESULT_TICKS) ? T_A : RESULT_TICKS;
   localparam int T_MAX = (T_B > BLINK_TICKS) ? T_B : BLINK_TICKS;
   localparam int CNT_W = $clog2(T_MAX + 1);

   localparam logic [CNT_W-1:0] ENGAGE_LAST    = CNT_W'(ENGAGE_TICKS - 1);
   localparam logic [CNT_W-1:0] COUNTDOWN_LAST = CNT_W'(COUNTDOWN_TICKS - 1);
   localparam logic [CNT_W-1:0] RESULT_LAST    = CNT_W'(RESULT_TICKS - 1);
   localparam logic [11:0]      TSZ            = 12'(TARGET_SIZE);
   localparam logic [3:0]       LAST_ROUND     = 4'(NUM_ROUNDS - 1);
   localparam logic [3:0]       MAX_GOALS      = 4'(NUM_ROUNDS);

   typedef enum logic [2:0] {
      S_IDLE, S_ENGAGE, S_COUNTDOWN, S_DECIDE, S_GOAL, S_SAVE, S_FINISH
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       round_q, round_d;
   logic [3:0]       goals_q, goals_d;
   logic [9:0]       sx_q, sx_d, sy_q, sy_d;
   logic             is_scored_q, is_scored_d;
   logic             round_done_q, round_done_d;
   logic             end_gk_q, end_gk_d;
   logic [1:0]       phase_q, phase_d;
   logic [4:0]       snap_x_q, snap_x_d;
   logic [9:0]       snap_y_q, snap_y_d;
   logic [7:0]       data_q, data_d;
   logic [10:0]      vcount_q, hcount_q;
   logic             vsync_q, vblnk_q, hsync_q, hblnk_q;
   logic [11:0]      rgb_q, rgb_d;

   logic        keeper, mouse_in, pix_in, show_cd;
   logic [11:0] x_lo, x_hi, y_lo, y_hi;

   // Inclusive target bounds in 12 bits: max 1023 + 1023 never wraps.
   always_comb begin
      x_lo     = {2'b00, sx_q};
      y_lo     = {2'b00, sy_q};
      x_hi     = x_lo + TSZ;
      y_hi     = y_lo + TSZ;
      keeper   = (game_state == GS_KEEPER);
      mouse_in = (xpos >= x_lo) && (xpos <= x_hi) && (ypos >= y_lo) && (ypos <= y_hi);
      pix_in   = ({1'b0, in.hcount} >= x_lo) && ({1'b0, in.hcount} <= x_hi) &&
                 ({1'b0, in.vcount} >= y_lo) && ({1'b0, in.vcount} <= y_hi);
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      round_d      = round_q;
      goals_d      = goals_q;
      sx_d         = sx_q;
      sy_d         = sy_q;
      round_done_d = 1'b0;
      end_gk_d     = 1'b0;
      if (state_q != S_IDLE && !keeper) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: if (keeper) begin
               state_d = S_ENGAGE;
               cnt_d   = '0;
               round_d = '0;
               goals_d = '0;
            end
            S_ENGAGE: if (cnt_q == ENGAGE_LAST) begin
               sx_d    = shot_xpos;
               sy_d    = shot_ypos;
               state_d = S_COUNTDOWN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
            S_COUNTDOWN: if (cnt_q == COUNTDOWN_LAST) begin
               state_d = S_DECIDE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
            S_DECIDE: begin
               cnt_d = '0;
               if (mouse_in) begin
                  state_d = S_SAVE;
               end else begin
                  state_d = S_GOAL;
                  if (goals_q != MAX_GOALS) goals_d = goals_q + 4'd1;
               end
            end
            S_GOAL, S_SAVE: if (cnt_q == RESULT_LAST) begin
               cnt_d        = '0;
               round_done_d = 1'b1;
               if (round_q == LAST_ROUND) begin
                  state_d = S_FINISH;
               end else begin
                  round_d = round_q + 4'd1;
                  state_d = S_ENGAGE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
            S_FINISH: begin
               end_gk_d = 1'b1;
               state_d  = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
      is_scored_d = (state_d == S_GOAL);
   end

`ifdef KEEPER_BLINK_EN
   localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_TICKS - 1);
   logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
   logic             blink_q, blink_d;

   always_comb begin
      blink_cnt_d = blink_cnt_q;
      blink_d     = blink_q;
      if (state_d == S_COUNTDOWN && state_q != S_COUNTDOWN) begin
         blink_d     = 1'b1;
         blink_cnt_d = '0;
      end else if (state_q == S_COUNTDOWN) begin
         if (blink_cnt_q == BLINK_LAST) begin
            blink_d     = ~blink_q;
            blink_cnt_d = '0;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
         end
      end
   end
   assign show_cd = blink_q;
`else
   assign show_cd = 1'b1;
`endif

   always_comb begin
      rgb_d = in.rgb;
      if (pix_in) begin
         case (state_q)
            S_COUNTDOWN: if (show_cd) rgb_d = 12'h00F;
            S_GOAL:      rgb_d = 12'hF00;
            S_SAVE:      rgb_d = 12'h0F0;
            default:     rgb_d = in.rgb;
         endcase
      end
   end

   // Phase 0 emits from the live target and snapshots it, so phases 1-3 stay coherent with it.
   always_comb begin
      phase_d  = phase_q + 2'd1;
      snap_x_d = snap_x_q;
      snap_y_d = snap_y_q;
      case (phase_q)
         2'd0: begin
            data_d   = {sx_q[4:0], 3'b001};
            snap_x_d = sx_q[9:5];
            snap_y_d = sy_q;
         end
         2'd1:    data_d = {snap_x_q, 3'b010};
         2'd2:    data_d = {snap_y_q[4:0], 3'b101};
         default: data_d = {snap_y_q[9:5], 3'b110};
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         round_q      <= '0;
         goals_q      <= '0;
         sx_q         <= '0;
         sy_q         <= '0;
         is_scored_q  <= 1'b0;
         round_done_q <= 1'b0;
         end_gk_q     <= 1'b0;
         phase_q      <= '0;
         snap_x_q     <= '0;
         snap_y_q     <= '0;
         data_q       <= '0;
         vcount_q     <= '0;
         vsync_q      <= 1'b0;
         vblnk_q      <= 1'b0;
         hcount_q     <= '0;
         hsync_q      <= 1'b0;
         hblnk_q      <= 1'b0;
         rgb_q        <= '0;
`ifdef KEEPER_BLINK_EN
         blink_cnt_q  <= '0;
         blink_q      <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         round_q      <= round_d;
         goals_q      <= goals_d;
         sx_q         <= sx_d;
         sy_q         <= sy_d;
         is_scored_q  <= is_scored_d;
         round_done_q <= round_done_d;
         end_gk_q     <= end_gk_d;
         phase_q      <= phase_d;
         snap_x_q     <= snap_x_d;
         snap_y_q     <= snap_y_d;
         data_q       <= data_d;
         vcount_q     <= in.vcount;
         vsync_q      <= in.vsync;
         vblnk_q      <= in.vblnk;
         hcount_q     <= in.hcount;
         hsync_q      <= in.hsync;
         hblnk_q      <= in.hblnk;
         rgb_q        <= rgb_d;
`ifdef KEEPER_BLINK_EN
         blink_cnt_q  <= blink_cnt_d;
         blink_q      <= blink_d;
`endif
      end
   end

   assign out.vcount       = vcount_q;
   assign out.vsync        = vsync_q;
   assign out.vblnk        = vblnk_q;
   assign out.hcount       = hcount_q;
   assign out.hsync        = hsync_q;
   assign out.hblnk        = hblnk_q;
   assign out.rgb          = rgb_q;
   assign is_scored        = is_scored_q;
   assign round_done       = round_done_q;
   assign goals            = goals_q;
   assign end_gk           = end_gk_q;
   assign data_to_transmit = data_q;

endmodule

// File: tb/tb_keeper_round_ctrl.sv
// Bench for keeper_round_ctrl: directed sessions with randomized shots, mouse and video,
// compared against a round-level reference model.
module tb_keeper_round_ctrl;
   localparam int         ENG = 20, CD = 20, RES = 8, TS = 10, NR = 2;
   localparam logic [1:0] GS_MENU = 2'd0, GS_KEEPER = 2'd2;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] xpos, ypos;
   logic [1:0]  game_state;
   logic [9:0]  shot_xpos, shot_ypos;
   logic        is_scored, round_done, end_gk;
   logic [3:0]  goals;
   logic [7:0]  data_to_transmit;

   vga_if vin ();
   vga_if vout ();

   keeper_round_ctrl #(
      .ENGAGE_TICKS(ENG), .COUNTDOWN_TICKS(CD), .RESULT_TICKS(RES),
      .TARGET_SIZE(TS), .NUM_ROUNDS(NR), .BLINK_TICKS(4), .GS_KEEPER(GS_KEEPER)
   ) dut (
      .clk(clk), .rst(rst), .xpos(xpos), .ypos(ypos), .game_state(game_state),
      .shot_xpos(shot_xpos), .shot_ypos(shot_ypos), .in(vin), .out(vout),
      .is_scored(is_scored), .round_done(round_done), .goals(goals),
      .end_gk(end_gk), .data_to_transmit(data_to_transmit)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int model_goals = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic bit inside_tgt(input logic [11:0] px, input logic [11:0] py,
                                     input logic [9:0] sx, input logic [9:0] sy);
      int x0 = int'(sx);
      int y0 = int'(sy);
      return (int'(px) >= x0) && (int'(px) <= x0 + TS) && (int'(py) >= y0) && (int'(py) <= y0 + TS);
   endfunction

   function automatic logic [7:0] frame(input int k, input logic [9:0] x, input logic [9:0] y);
      case (k)
         0:       return {x[4:0], 3'b001};
         1:       return {x[9:5], 3'b010};
         2:       return {y[4:0], 3'b101};
         default: return {y[9:5], 3'b110};
      endcase
   endfunction

   task automatic rand_video();
      vin.vcount = 11'($urandom);
      vin.hcount = 11'($urandom);
      vin.vsync  = 1'($urandom);
      vin.vblnk  = 1'($urandom);
      vin.hsync  = 1'($urandom);
      vin.hblnk  = 1'($urandom);
      vin.rgb    = 12'($urandom);
   endtask

   // Four consecutive frames must be a rotation of the expected cycle.
   task automatic check_frames(input logic [7:0] e0, input logic [7:0] e1,
                               input logic [7:0] e2, input logic [7:0] e3, input string tag);
      logic [7:0] e[4];
      logic [7:0] s[4];
      int k0 = 0;
      e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
      for (int i = 0; i < 4; i++) begin
         tick();
         s[i] = data_to_transmit;
      end
      for (int k = 0; k < 4; k++) if (s[0] == e[k]) k0 = k;
      for (int i = 0; i < 4; i++) chk({tag, " frame"}, 32'(s[i]), 32'(e[(k0 + i) % 4]));
   endtask

   task automatic rand_mouse(input logic [9:0] sx, input logic [9:0] sy,
                             output logic [11:0] mx, output logic [11:0] my);
      if ($urandom_range(0, 1) == 1) begin
         mx = 12'(int'(sx) + int'($urandom_range(0, TS)));
         my = 12'(int'(sy) + int'($urandom_range(0, TS)));
      end else begin
         mx = 12'($urandom_range(0, 1100));
         my = 12'($urandom_range(0, 1100));
      end
   endtask

   // Entered right after the edge that put the controller into ENGAGE for this round.
   task automatic run_round(input logic [9:0] sx, input logic [9:0] sy, input logic [11:0] mx,
                            input logic [11:0] my, input bit last, input string tag);
      bit          save;
      logic [11:0] in_rgb;
      shot_xpos = sx;
      shot_ypos = sy;
      xpos = 12'($urandom);
      ypos = 12'($urandom);
      repeat (ENG) tick();
      shot_xpos = 10'($urandom);
      shot_ypos = 10'($urandom);
      rand_video();
      vin.hcount = 11'(int'(sx) + int'($urandom_range(0, TS)));
      vin.vcount = 11'(int'(sy) + int'($urandom_range(0, TS)));
      tick();
      chk({tag, " cd_in"}, 32'(vout.rgb), 32'h00F);
      rand_video();
      vin.hcount = 11'(int'(sx) + TS + 1);
      vin.vcount = 11'(sy);
      in_rgb = vin.rgb;
      tick();
      chk({tag, " cd_out"}, 32'(vout.rgb), 32'(in_rgb));
      repeat (4) tick();
      check_frames(frame(0, sx, sy), frame(1, sx, sy), frame(2, sx, sy), frame(3, sx, sy), tag);
      repeat (CD - 10) tick();
      xpos = mx;
      ypos = my;
      tick();
      xpos = 12'($urandom);
      ypos = 12'($urandom);
      save = inside_tgt(mx, my, sx, sy);
      if (!save && model_goals < NR) model_goals++;
      chk({tag, " scored"}, 32'(is_scored), 32'(!save));
      chk({tag, " goals"}, 32'(goals), 32'(model_goals));
      rand_video();
      vin.hcount = 11'(int'(sx) + TS);
      vin.vcount = 11'(int'(sy) + TS);
      tick();
      chk({tag, " res_corner"}, 32'(vout.rgb), save ? 32'h0F0 : 32'hF00);
      rand_video();
      vin.hcount = 11'(int'(sx) + TS + 1);
      vin.vcount = 11'(int'(sy) + TS);
      in_rgb = vin.rgb;
      tick();
      chk({tag, " res_out"}, 32'(vout.rgb), 32'(in_rgb));
      repeat (RES - 3) tick();
      chk({tag, " scored_end"}, 32'(is_scored), 32'(!save));
      chk({tag, " no_early_done"}, 32'(round_done), 32'd0);
      tick();
      chk({tag, " round_done"}, 32'(round_done), 32'd1);
      chk({tag, " scored_clr"}, 32'(is_scored), 32'd0);
      chk({tag, " no_early_end"}, 32'(end_gk), 32'd0);
      if (last) begin
         tick();
         chk({tag, " end_gk"}, 32'(end_gk), 32'd1);
         chk({tag, " done_width"}, 32'(round_done), 32'd0);
         game_state = GS_MENU;
         tick();
         chk({tag, " end_width"}, 32'(end_gk), 32'd0);
         chk({tag, " goals_held"}, 32'(goals), 32'(model_goals));
      end
   endtask

   initial begin
      logic [11:0] mx, my;
      logic [9:0]  sx, sy;
      int          n_done, n_end;

      rst = 1'b1;
      game_state = GS_MENU;
      xpos = '0; ypos = '0; shot_xpos = '0; shot_ypos = '0;
      rand_video();
      tick();
      tick();
      chk("rst rgb", 32'(vout.rgb), 32'd0);
      chk("rst goals", 32'(goals), 32'd0);
      chk("rst scored", 32'(is_scored), 32'd0);
      chk("rst done", 32'(round_done), 32'd0);
      chk("rst end", 32'(end_gk), 32'd0);
      chk("rst data", 32'(data_to_transmit), 32'd0);
      rst = 1'b0;

      // Idle pass-through of every video field.
      rand_video();
      tick();
      chk("idle vcount", 32'(vout.vcount), 32'(vin.vcount));
      chk("idle vsync", 32'(vout.vsync), 32'(vin.vsync));
      chk("idle vblnk", 32'(vout.vblnk), 32'(vin.vblnk));
      chk("idle hcount", 32'(vout.hcount), 32'(vin.hcount));
      chk("idle hsync", 32'(vout.hsync), 32'(vin.hsync));
      chk("idle hblnk", 32'(vout.hblnk), 32'(vin.hblnk));
      chk("idle rgb", 32'(vout.rgb), 32'(vin.rgb));
      check_frames(8'h01, 8'h02, 8'h05, 8'h06, "idle");

      // Session 1: directed save then goal.
      model_goals = 0;
      game_state = GS_KEEPER;
      tick();
      run_round(10'd100, 10'd200, 12'd105, 12'd205, 1'b0, "s1r1");
      run_round(10'd100, 10'd200, 12'd99, 12'd205, 1'b1, "s1r2");

      // Session 2: randomized shots and mouse.
      model_goals = 0;
      game_state = GS_KEEPER;
      tick();
      chk("s2 goals_clr", 32'(goals), 32'd0);
      for (int r = 0; r < NR; r++) begin
         sx = 10'($urandom);
         sy = 10'($urandom);
         rand_mouse(sx, sy, mx, my);
         run_round(sx, sy, mx, my, r == NR - 1, "s2");
      end

      // Session 3: abort during ENGAGE of round 2.
      model_goals = 0;
      game_state = GS_KEEPER;
      tick();
      run_round(10'h3FF, 10'h155, 12'd0, 12'd0, 1'b0, "s3r1");
      repeat (3) tick();
      game_state = GS_MENU;
      n_done = 0;
      n_end = 0;
      for (int i = 0; i < 60; i++) begin
         shot_xpos = 10'($urandom);
         shot_ypos = 10'($urandom);
         tick();
         if (round_done) n_done++;
         if (end_gk) n_end++;
      end
      chk("abort done", 32'(n_done), 32'd0);
      chk("abort end", 32'(n_end), 32'd0);
      chk("abort goals", 32'(goals), 32'(model_goals));
      chk("abort scored", 32'(is_scored), 32'd0);
      rand_video();
      vin.hcount = 11'h3FF;
      vin.vcount = 11'h155;
      tick();
      chk("abort rgb", 32'(vout.rgb), 32'(vin.rgb));
      check_frames(8'hF9, 8'hFA, 8'hAD, 8'h56, "latched");

      // Session 4: reset asserted mid-countdown.
      model_goals = 0;
      game_state = GS_KEEPER;
      tick();
      sx = 10'($urandom_range(1, 1023));
      sy = 10'($urandom);
      run_round(sx, sy, 12'd0, 12'd0, 1'b0, "s4r1");
      sx = 10'($urandom);
      sy = 10'($urandom);
      shot_xpos = sx;
      shot_ypos = sy;
      repeat (ENG + 3) tick();
      rand_video();
      vin.hcount = 11'(sx);
      vin.vcount = 11'(sy);
      tick();
      chk("s4 cd_rgb", 32'(vout.rgb), 32'h00F);
      #2 rst = 1'b1;
      #1;
      chk("async rgb", 32'(vout.rgb), 32'd0);
      chk("async goals", 32'(goals), 32'd0);
      chk("async data", 32'(data_to_transmit), 32'd0);
      chk("async scored", 32'(is_scored), 32'd0);
      game_state = GS_MENU;
      tick();
      rst = 1'b0;
      rand_video();
      tick();
      chk("post_rst rgb", 32'(vout.rgb), 32'(vin.rgb));
      chk("post_rst goals", 32'(goals), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
